program_sequencer: RTL and testbench
====================================

// Module: program_sequencer
// PURPOSE
//  Program counter and fetch sequencer for the 8-bit microcontroller core.
//  - Computes pm_addr for the program ROM each cycle from the decoder's jmp/jmp_nz and the ALU zero flag.
//  - Generates the core-wide synchronous sync_reset from the board-level asynchronous reset.
//  - Optional debug halt/single-step control.
// PARAMETERS
//  PC_W        8  program counter / pm_addr width
//  NIB_W       4  width of jump target nibble from decoder (ir_nibble)
//  RST_CYCLES  4  cycles sync_reset stays high after reset_n deassertion is synchronised (>=1)
// PORTS
//  clk         in   1      core clock
//  reset_n     in   1      asynchronous, active-low reset
//  jmp         in   1      unconditional jump (decoder)
//  jmp_nz      in   1      conditional jump (decoder)
//  dont_jmp    in   1      ALU zero flag; 1 suppresses jmp_nz
//  ir_nibble   in   NIB_W  jump target low bits
//  halt_req    in   1      debug halt request (level)
//  step        in   1      debug single-step pulse (1 cycle)
//  sync_reset  out  1      synchronous active-high reset to decoder/datapath
//  pm_addr     out  PC_W   ROM address (combinational next PC)
//  pc          out  PC_W   current program counter (registered)
//  halted      out  1      core stalled; datapath gates all reg_en with !halted
// BEHAVIOUR
//  Reset: reset_n=0 asynchronously forces sync_reset=1, pc=0, state=RST, halted=0.
//  - reset_n rise passes a 2-flop synchroniser, then a counter holds sync_reset=1 for RST_CYCLES more cycles.
//  - reset_n low mid-count restarts the whole sequence.
//  States:
//  - RST: sync_reset=1, pm_addr=0, pc<=0. Counter done -> RUN.
//  - RUN: pm_addr = next; pc<=pm_addr. halt_req=1 at edge -> HALT (that edge's advance still happens).
//  - HALT: pm_addr=pc, pc holds, halted=1.
//    - step=1 -> pm_addr=next for that cycle only, pc<=next, stay HALT.
//    - halt_req=0 -> RUN; step in the same cycle acts as a normal advance.
//  next (priority high->low):
//  - jmp -> {pc[PC_W-1:NIB_W], ir_nibble}
//  - jmp_nz & !dont_jmp -> same target
//  - else pc+1 (mod 2^PC_W; 8'hFF wraps to 8'h00)
//  Jump and jmp_nz both set: jmp wins (same target).
//  Latency: pc follows pm_addr by exactly 1 cycle; no bubbles in RUN.
//  Outputs in RST: pm_addr=0, halted=0. Jump/step inputs are ignored while sync_reset=1.
// CONFIGURATION
//  PS_SINGLE_STEP_EN defined: HALT state, halt_req/step behave as above.
//  Undefined: FSM is RST/RUN only; halt_req and step ignored; halted tied 0.
// STRUCTURE
//  Shared package cpu_pkg: PC_W, NIB_W, ps_state_t enum {PS_RST, PS_RUN, PS_HALT}.
//  Sub-module reset_stretcher (synchroniser + RST_CYCLES counter) owns sync_reset.
//  PC/next logic and FSM stay in program_sequencer.
// TESTING
//  1. reset_n low 3 cycles, release: sync_reset stays 1 for 2+4 cycles, then 0; pc=0.
//     pm_addr = 01,02,03 on the following cycles.
//  2. pc=8'h35, jmp=1, ir_nibble=4'hA -> pm_addr=8'h3A, pc=8'h3A next cycle.
//  3. pc=8'h20, jmp_nz=1, ir_nibble=4'h7:
//     dont_jmp=0 -> pc=8'h27; dont_jmp=1 -> pc=8'h21.
//  4. pc=8'hFF, no jump -> pm_addr=8'h00.
//     reset_n pulsed low mid-RUN -> pm_addr=0 and sync_reset=1 immediately (async).
//  5. PS_SINGLE_STEP_EN: halt_req=1 at pc=8'h10 -> pc=8'h11 then holds, halted=1.
//     Two step pulses -> 8'h12, 8'h13. halt_req=0 -> resumes 8'h14.
//  6. Without PS_SINGLE_STEP_EN: halt_req=1, step toggling -> pc increments every cycle, halted=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, reset stretch length and program sequencer state encoding.
package cpu_pkg;
  localparam int PC_W = 8;
  localparam int NIB_W = 4;
  localparam int RST_CYCLES = 4;
  typedef enum logic [1:0] {PS_RST, PS_RUN, PS_HALT} ps_state_t;
endpackage

// File: rtl/reset_stretcher.sv
// reset_stretcher: 2-flop synchroniser on rst_ni release, then holds sync_reset_o for RST_CYCLES more cycles.
module reset_stretcher #(
  parameter int RST_CYCLES = cpu_pkg::RST_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic sync_reset_o,
  output logic done_o
);
  localparam int CW = $clog2(RST_CYCLES + 1);
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          rst_q;
  // done_o flags the edge at which sync_reset_o drops, so the FSM can leave RST on that same edge
  assign done_o = rst_q & sync_q[1] & (cnt_q == CW'(RST_CYCLES - 1));
  assign sync_reset_o = rst_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      cnt_q  <= '0;
      rst_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
      if (rst_q & sync_q[1]) cnt_q <= cnt_q + CW'(1);
      rst_q <= rst_q & ~done_o;
    end
  end
endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: PC and fetch address sequencing with stretched synchronous reset.
// Define PS_SINGLE_STEP_EN to add the debug HALT state (halt_req / step); otherwise halted is tied 0.
module program_sequencer #(
  parameter int PC_W       = cpu_pkg::PC_W,
  parameter int NIB_W      = cpu_pkg::NIB_W,
  parameter int RST_CYCLES = cpu_pkg::RST_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             jmp,
  input  logic             jmp_nz,
  input  logic             dont_jmp,
  input  logic [NIB_W-1:0] ir_nibble,
  input  logic             halt_req,
  input  logic             step,
  output logic             sync_reset,
  output logic [PC_W-1:0]  pm_addr,
  output logic [PC_W-1:0]  pc,
  output logic             halted
);
  import cpu_pkg::*;
  ps_state_t       state_q, state_d;
  logic [PC_W-1:0] pc_q, nxt;
  logic            halted_q, done;
  reset_stretcher #(.RST_CYCLES(RST_CYCLES)) u_rst (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .sync_reset_o(sync_reset),
    .done_o      (done)
  );
  assign nxt = (jmp | (jmp_nz & ~dont_jmp)) ? {pc_q[PC_W-1:NIB_W], ir_nibble} : pc_q + PC_W'(1);
`ifdef PS_SINGLE_STEP_EN
  always_comb begin
    pm_addr = (state_q == PS_RST) ? '0 : (state_q == PS_HALT && halt_req && !step) ? pc_q : nxt;
    state_d = (state_q == PS_RST) ? (done ? PS_RUN : PS_RST) : (halt_req ? PS_HALT : PS_RUN);
  end
`else
  logic unused_dbg;
  assign unused_dbg = halt_req ^ step;
  always_comb begin
    pm_addr = (state_q == PS_RST) ? '0 : nxt;
    state_d = (state_q == PS_RST && !done) ? PS_RST : PS_RUN;
  end
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= PS_RST;
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pm_addr;
      halted_q <= (state_d == PS_HALT);
    end
  end
  assign pc = pc_q;
  assign halted = halted_q;
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed plus random checks of program_sequencer against a behavioural PC model.
module tb_program_sequencer;
  logic       clk = 1'b0, reset_n = 1'b1;
  logic       jmp = 1'b0, jmp_nz = 1'b0, dont_jmp = 1'b0, halt_req = 1'b0, step = 1'b0;
  logic [3:0] ir_nibble = '0;
  logic       sync_reset, halted;
  logic [7:0] pm_addr, pc;
  int         n_chk = 0, n_fail = 0;
  logic [7:0] m_pc = '0;
  bit         m_halt = 1'b0;

  always #5 clk = ~clk;

  program_sequencer dut (
    .clk(clk), .reset_n(reset_n), .jmp(jmp), .jmp_nz(jmp_nz), .dont_jmp(dont_jmp),
    .ir_nibble(ir_nibble), .halt_req(halt_req), .step(step),
    .sync_reset(sync_reset), .pm_addr(pm_addr), .pc(pc), .halted(halted)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_next(input logic [7:0] p, input bit j, input bit jn,
                                          input bit dj, input logic [3:0] nib);
    int t;
    if (j || (jn && !dj)) t = (p & 8'hF0) + nib;
    else t = (p + 1) % 256;
    return 8'(t);
  endfunction

  task automatic cyc(input bit j, input bit jn, input bit dj, input logic [3:0] nib,
                     input bit hr, input bit st);
    logic [7:0] e;
    jmp = j; jmp_nz = jn; dont_jmp = dj; ir_nibble = nib; halt_req = hr; step = st;
    e = ref_next(m_pc, j, jn, dj, nib);
`ifdef PS_SINGLE_STEP_EN
    if (m_halt && hr && !st) e = m_pc;
`endif
    @(negedge clk);
    check("pm_addr", pm_addr, e);
    check("halted", {7'b0, halted}, {7'b0, m_halt});
    check("sync_reset_run", {7'b0, sync_reset}, 8'h00);
    @(posedge clk); #1;
    check("pc", pc, e);
    m_pc = e;
`ifdef PS_SINGLE_STEP_EN
    m_halt = hr;
`endif
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("async_sync_reset", {7'b0, sync_reset}, 8'h01);
    check("async_pm_addr", pm_addr, 8'h00);
    check("async_pc", pc, 8'h00);
    check("async_halted", {7'b0, halted}, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      jmp = 1'b1; jmp_nz = 1'($urandom % 2); ir_nibble = 4'($urandom);
      halt_req = 1'($urandom % 2); step = 1'($urandom % 2);
      @(posedge clk); #1;
      check("rst_sync_reset", {7'b0, sync_reset}, (k < 6) ? 8'h01 : 8'h00);
      check("rst_pc", pc, 8'h00);
      check("rst_halted", {7'b0, halted}, 8'h00);
    end
    m_pc = 8'h00;
    m_halt = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();
    repeat (3) cyc(0, 0, 0, 4'h0, 0, 0);
    check("after_reset_pc3", pc, 8'h03);
    for (int i = 0; i < 300 && m_pc != 8'h35; i++) cyc(0, 0, 0, 4'h0, 0, 0);
    check("reach_35", pc, 8'h35);
    cyc(1, 0, 0, 4'hA, 0, 0);
    check("jmp_3A", pc, 8'h3A);
    for (int i = 0; i < 300 && m_pc != 8'h20; i++) cyc(0, 0, 0, 4'h0, 0, 0);
    cyc(0, 1, 0, 4'h7, 0, 0);
    check("jnz_taken_27", pc, 8'h27);
    cyc(1, 0, 0, 4'h0, 0, 0);
    cyc(0, 1, 1, 4'h7, 0, 0);
    check("jnz_suppressed_21", pc, 8'h21);
    cyc(1, 1, 1, 4'h5, 0, 0);
    check("jmp_wins_25", pc, 8'h25);
    for (int i = 0; i < 300 && m_pc != 8'hFF; i++) cyc(0, 0, 0, 4'h0, 0, 0);
    cyc(0, 0, 0, 4'h0, 0, 0);
    check("wrap_00", pc, 8'h00);
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom % 4 == 0), 1'($urandom % 2), 1'($urandom % 2), 4'($urandom),
          1'($urandom % 3 == 0), 1'($urandom % 3 == 0));
`ifdef PS_SINGLE_STEP_EN
    for (int i = 0; i < 300 && (m_pc != 8'h10 || m_halt); i++) cyc(0, 0, 0, 4'h0, 0, 0);
    cyc(0, 0, 0, 4'h0, 1, 0);
    check("halt_edge_11", pc, 8'h11);
    cyc(0, 0, 0, 4'h0, 1, 0);
    check("halt_hold_11", pc, 8'h11);
    check("halt_flag", {7'b0, halted}, 8'h01);
    cyc(0, 0, 0, 4'h0, 1, 1);
    check("step1_12", pc, 8'h12);
    cyc(0, 0, 0, 4'h0, 1, 0);
    cyc(0, 0, 0, 4'h0, 1, 1);
    check("step2_13", pc, 8'h13);
    cyc(0, 0, 0, 4'h0, 0, 0);
    check("resume_14", pc, 8'h14);
`else
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 4'h0, 1, 1'(i % 2));
      check("nohalt_flag", {7'b0, halted}, 8'h00);
    end
`endif
    #2;
    do_reset();
    repeat (4) cyc(0, 0, 0, 4'h0, 0, 0);
    check("post_reset_pc4", pc, 8'h04);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
